flash_word_fetch: RTL and testbench
===================================

Name: flash_word_fetch

Overview:
- Sits between the instruction-fetch bus and the QSPI flash byte reader. Turns 32-bit word read requests into sequential byte streams on the reader's addr/do_read interface.
- Assembles the returned bytes little-endian. Keeps the flash stream open across consecutive sequential requests so that only non-sequential jumps pay the restart cost.

Parameters:
- ADDR_W, 24, flash byte-address width; must match the reader's addr width.

Ports:
- clk  in  1  system clock; the same clock as the flash reader's host clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  word read request
- req_addr  in  ADDR_W  byte address; bits [1:0] ignored and treated as 0
- req_ready  out  1  request accepted when req_valid && req_ready
- resp_valid  out  1  single-cycle pulse, no backpressure
- resp_data  out  32  assembled word; first flash byte in [7:0]
- flash_setup_done  in  1  from reader
- flash_addr  out  ADDR_W  to reader
- flash_do_read  out  1  to reader
- flash_data_ready  in  1  from reader, byte strobe
- flash_data  in  8  from reader

Behaviour:
- Reset values (async): req_ready=0, resp_valid=0, resp_data=0, flash_do_read=0, flash_addr=0, state=IDLE, stream_live=0, next_addr=0.
- States:
  - IDLE: req_ready = flash_setup_done.
  - GAP: do_read=0 for exactly 1 cycle; flash_addr holds the new address.
  - STREAM: do_read=1; collects 4 bytes.
- Accept in IDLE:
  - Latch A = {req_addr[ADDR_W-1:2], 2'b00}.
  - If stream_live && A == next_addr: go to STREAM directly; flash_do_read stays high.
  - Otherwise: flash_addr <= A, go to GAP, then STREAM.
- STREAM byte handling:
  - Each flash_data_ready shifts flash_data into byte lane byte_cnt (0..3).
  - On the 4th byte: resp_valid=1 the next cycle; next_addr <= A+4 (mod 2^ADDR_W); stream_live=1; state=IDLE.
  - Response latency from accept: 4 bytes plus 1 cycle (plus 1 cycle GAP when non-sequential).
- IDLE with stream_live: flash_do_read stays 1.
  - A flash_data_ready arriving before a request is accepted is handled per the optional feature.
  - A request accepted in the same cycle as a flash_data_ready uses that byte as lane 0 when sequential.
- Wrap: if A+4 overflows to 0, stream_live is cleared. A request at 0 then always takes GAP; the flash's internal wrap is not trusted.
- flash_setup_done low: req_ready=0, flash_do_read=0, stream_live cleared.
- Reset mid-stream: everything returns to reset values; partial words are discarded and no resp_valid is emitted.
- resp_valid is never asserted in two consecutive cycles.

Optional Feature:
- Macro: FLASH_WORD_FETCH_PREFETCH_EN.
- Defined:
  - IDLE with stream_live captures unrequested bytes into a one-word prefetch buffer tagged next_addr.
  - When the buffer holds 4 bytes and no request is pending, drop flash_do_read and clear stream_live; the buffer stays valid.
  - A request equal to the buffer tag is answered with resp_valid the cycle after accept, without flash activity. The buffer is then invalidated; if the stream is still live it continues.
  - A miss invalidates the buffer and takes GAP.
- Undefined:
  - Any flash_data_ready in IDLE drops flash_do_read and clears stream_live; the byte is discarded.
  - The next request always takes GAP.

Decomposition:
- Shared flash package:
  - FLASH_ADDR_W=24
  - state enum {IDLE, GAP, STREAM}
  - WORD_BYTES=4
- Sub-module flash_word_assembler: byte-lane counter plus 32-bit shift/insert register with clear and done pulse. Reused by the prefetch buffer.

Test Plan:
- Reset with flash_setup_done=0, req_valid=1 -> req_ready=0, flash_do_read=0; after setup_done=1, req_ready=1 in the next cycle.
- Request 0x000100, model returns 11 22 33 44 -> do_read low exactly 1 cycle with flash_addr=0x000100, then resp_data=0x44332211, one resp_valid pulse.
- Request 0x000100, then 0x000104 presented in the resp cycle, bytes 55 66 77 88 -> flash_do_read never deasserts, resp_data=0x88776655.
- 0x000100 then 0x000203 -> one-cycle GAP, flash_addr=0x000200; the low addr bits are ignored.
- Request 0xFFFFFC then 0x000000 -> GAP forced for the second request despite arithmetic sequentiality.
- Request 0x100, then 0x104 delayed 12 cycles:
  - With PREFETCH_EN: resp 1 cycle after accept, no GAP.
  - Without: do_read drops on the first unrequested byte, and 0x104 takes GAP.

Source files
------------

// File: rtl/flash_word_fetch_pkg.sv
// Shared constants and FSM state type for the flash word fetcher.
package flash_word_fetch_pkg;
    localparam int FLASH_ADDR_W = 24;
    localparam int WORD_BYTES   = 4;
    localparam int CNT_W        = $clog2(WORD_BYTES + 1);

    typedef enum logic [1:0] {IDLE, GAP, STREAM} state_e;
endpackage

// File: rtl/flash_word_fetch_if.sv
// Fetch-bus request/response plus flash byte-reader signals; master = environment, slave = fetcher.
interface flash_word_fetch_if #(parameter int ADDR_W = 24);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic              flash_setup_done;
    logic [ADDR_W-1:0] flash_addr;
    logic              flash_do_read;
    logic              flash_data_ready;
    logic [7:0]        flash_data;

    modport master (
        output req_valid, req_addr, flash_setup_done, flash_data_ready, flash_data,
        input  req_ready, resp_valid, resp_data, flash_addr, flash_do_read
    );
    modport slave (
        input  req_valid, req_addr, flash_setup_done, flash_data_ready, flash_data,
        output req_ready, resp_valid, resp_data, flash_addr, flash_do_read
    );
endinterface

// File: rtl/flash_word_fetch_assembler.sv
// Little-endian byte-lane assembler: inserts bytes at lane cnt, saturates when full, clear wins.
module flash_word_assembler
    import flash_word_fetch_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    byte_vld_i,
    input  logic [7:0]              byte_i,
    output logic                    full_o,
    output logic                    done_o,
    output logic [8*WORD_BYTES-1:0] word_o,
    output logic [8*WORD_BYTES-1:0] word_nxt_o
);
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [8*WORD_BYTES-1:0] word_q, word_d;

    assign full_o = (cnt_q == CNT_W'(WORD_BYTES));
    assign done_o = byte_vld_i && (cnt_q == CNT_W'(WORD_BYTES - 1));
    assign word_o = word_q;

    // Word as it would look with byte_i inserted; lets the consumer grab the final byte same cycle
    always_comb begin
        word_nxt_o = word_q;
        for (int i = 0; i < WORD_BYTES; i++)
            if (cnt_q == CNT_W'(i)) word_nxt_o[8*i +: 8] = byte_i;
    end

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clr_i) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (byte_vld_i && !full_o) begin
            cnt_d  = cnt_q + CNT_W'(1);
            word_d = word_nxt_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end
endmodule

// File: rtl/flash_word_fetch.sv
// Word fetch over a sequential flash byte stream; keeps the stream open across sequential words.
// Optional FLASH_WORD_FETCH_PREFETCH_EN: buffer one unrequested word while the stream idles.
module flash_word_fetch
    import flash_word_fetch_pkg::*;
#(
    parameter int ADDR_W = FLASH_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    flash_word_fetch_if.slave bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] a_q, a_d, nxt_q, nxt_d, faddr_q, faddr_d, req_a, a_inc;
    logic              live_q, live_d, rdy_q, rvld_q, rvld_d;
    logic [31:0]       rdata_q, rdata_d, asm_word, asm_nxt;
    logic              accept, seq, compl, asm_clr, asm_vld, asm_full, asm_done;

    assign req_a  = {bus.req_addr[ADDR_W-1:2], 2'b00};
    assign a_inc  = ((state_q == IDLE) ? req_a : a_q) + ADDR_W'(WORD_BYTES);
    assign seq    = live_q && (req_a == nxt_q);
    assign accept = bus.req_valid && bus.req_ready;

    assign bus.req_ready     = rdy_q && bus.flash_setup_done && (state_q == IDLE);
    assign bus.flash_do_read = bus.flash_setup_done &&
                               ((state_q == STREAM) || ((state_q == IDLE) && live_q));
    assign bus.flash_addr    = faddr_q;
    assign bus.resp_valid    = rvld_q;
    assign bus.resp_data     = rdata_q;

    flash_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (asm_clr),
        .byte_vld_i (asm_vld),
        .byte_i     (bus.flash_data),
        .full_o     (asm_full),
        .done_o     (asm_done),
        .word_o     (asm_word),
        .word_nxt_o (asm_nxt)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        nxt_d   = nxt_q;
        faddr_d = faddr_q;
        live_d  = live_q;
        rvld_d  = 1'b0;
        rdata_d = rdata_q;
        compl   = 1'b0;
        asm_clr = 1'b0;
        asm_vld = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d = req_a;
`ifdef FLASH_WORD_FETCH_PREFETCH_EN
                    if (asm_full && (req_a == nxt_q)) begin
                        compl = 1'b1;
                    end else
`endif
                    if (seq) begin
                        // Sequential: a byte arriving this cycle is already lane 0 of the new word
                        asm_vld = bus.flash_data_ready;
                        if (asm_done) compl = 1'b1;
                        else          state_d = STREAM;
                    end else begin
                        asm_clr = 1'b1;
                        live_d  = 1'b0;
                        faddr_d = req_a;
                        state_d = GAP;
                    end
                end else if (live_q && bus.flash_data_ready) begin
`ifdef FLASH_WORD_FETCH_PREFETCH_EN
                    asm_vld = 1'b1;
                    if (asm_done) live_d = 1'b0;
`else
                    live_d = 1'b0;
`endif
                end
            end
            GAP: state_d = STREAM;
            STREAM: begin
                asm_vld = bus.flash_data_ready;
                if (asm_done) begin
                    compl  = 1'b1;
                    live_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (compl) begin
            rvld_d  = 1'b1;
            rdata_d = asm_full ? asm_word : asm_nxt;
            asm_clr = 1'b1;
            state_d = IDLE;
            nxt_d   = a_inc;
            // The flash's own address wrap is not trusted; force a restart at 0
            if (a_inc == '0) live_d = 1'b0;
        end
        if (!bus.flash_setup_done) begin
            live_d = 1'b0;
            if (!asm_full && (state_q == IDLE)) asm_clr = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            nxt_q   <= '0;
            faddr_q <= '0;
            live_q  <= 1'b0;
            rdy_q   <= 1'b0;
            rvld_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            nxt_q   <= nxt_d;
            faddr_q <= faddr_d;
            live_q  <= live_d;
            rdy_q   <= 1'b1;
            rvld_q  <= rvld_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_flash_word_fetch.sv
// Directed bench for flash_word_fetch; expectations follow FLASH_WORD_FETCH_PREFETCH_EN when defined.
module tb_flash_word_fetch;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   passed = 0;
    int   fails = 0;
    int   resp_cnt = 0;
    int   dr_low = 0;
    int   consec = 0;
    logic prev_rv = 1'b0;
    int   rc0, dl0;

    always #5 clk = ~clk;

    flash_word_fetch_if #(.ADDR_W(24)) bus ();

    flash_word_fetch #(.ADDR_W(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) begin
        if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
        if (bus.resp_valid && prev_rv) consec <= consec + 1;
        if (!bus.flash_do_read) dr_low <= dr_low + 1;
        prev_rv <= bus.resp_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic feed(input logic [7:0] b);
        bus.flash_data_ready = 1'b1;
        bus.flash_data       = b;
        tick();
        bus.flash_data_ready = 1'b0;
    endtask

    task automatic req(input logic [23:0] a);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        tick();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        rst                  = 1'b1;
        bus.flash_setup_done = 1'b0;
        bus.req_valid        = 1'b1;
        bus.req_addr         = 24'h0;
        bus.flash_data_ready = 1'b0;
        bus.flash_data       = 8'h0;
        tick(); tick();
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_do_read", bus.flash_do_read, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_data", bus.resp_data, 0);
        check("rst_flash_addr", bus.flash_addr, 0);
        rst = 1'b0;
        tick();
        check("nosetup_req_ready", bus.req_ready, 0);
        check("nosetup_do_read", bus.flash_do_read, 0);
        bus.req_valid        = 1'b0;
        bus.flash_setup_done = 1'b1;
        tick();
        check("setup_req_ready", bus.req_ready, 1);

        // Cold request: one GAP cycle then four bytes
        req(24'h000100);
        check("gap_do_read", bus.flash_do_read, 0);
        check("gap_flash_addr", bus.flash_addr, 24'h000100);
        check("gap_no_resp", bus.resp_valid, 0);
        rc0 = resp_cnt;
        tick();
        check("stream_do_read", bus.flash_do_read, 1);
        feed(8'h11); feed(8'h22); feed(8'h33); feed(8'h44);
        check("cold_resp_valid", bus.resp_valid, 1);
        check("cold_resp_data", bus.resp_data, 32'h44332211);

        // Sequential request presented in the response cycle
        dl0 = dr_low;
        req(24'h000104);
        check("resp_single_pulse", bus.resp_valid, 0);
        check("resp_count", resp_cnt - rc0, 1);
        feed(8'h55); feed(8'h66); feed(8'h77); feed(8'h88);
        check("seq_resp_valid", bus.resp_valid, 1);
        check("seq_resp_data", bus.resp_data, 32'h88776655);
        check("seq_do_read_held", dr_low - dl0, 0);

        // Sequential accept with a byte in the same cycle: that byte is lane 0
        bus.req_valid = 1'b1;
        bus.req_addr  = 24'h000108;
        feed(8'h99);
        bus.req_valid = 1'b0;
        feed(8'hAA); feed(8'hBB); feed(8'hCC);
        check("lane0_resp_data", bus.resp_data, 32'hCCBBAA99);

        // Non-sequential jumps; low address bits ignored
        req(24'h000100);
        check("jump_do_read", bus.flash_do_read, 0);
        check("jump_flash_addr", bus.flash_addr, 24'h000100);
        tick();
        feed(8'h01); feed(8'h02); feed(8'h03); feed(8'h04);
        check("jump_resp_data", bus.resp_data, 32'h04030201);
        req(24'h000203);
        check("unaligned_do_read", bus.flash_do_read, 0);
        check("unaligned_flash_addr", bus.flash_addr, 24'h000200);
        tick();
        feed(8'hA1); feed(8'hA2); feed(8'hA3); feed(8'hA4);
        check("unaligned_resp_data", bus.resp_data, 32'hA4A3A2A1);

        // Top-of-space word: wrap to 0 must restart with a GAP
        req(24'hFFFFFC);
        check("top_flash_addr", bus.flash_addr, 24'hFFFFFC);
        tick();
        feed(8'hC1); feed(8'hC2); feed(8'hC3); feed(8'hC4);
        check("top_resp_data", bus.resp_data, 32'hC4C3C2C1);
        check("wrap_stream_dropped", bus.flash_do_read, 0);
        req(24'h000000);
        check("wrap_gap_do_read", bus.flash_do_read, 0);
        check("wrap_gap_flash_addr", bus.flash_addr, 24'h000000);
        tick();
        feed(8'h0F); feed(8'h1F); feed(8'h2F); feed(8'h3F);
        check("wrap_resp_data", bus.resp_data, 32'h3F2F1F0F);

        // Delayed sequential request with unrequested bytes in between
        req(24'h000100);
        check("pf_gap_flash_addr", bus.flash_addr, 24'h000100);
        tick();
        feed(8'h11); feed(8'h22); feed(8'h33); feed(8'h44);
        check("pf_base_resp_data", bus.resp_data, 32'h44332211);
        feed(8'hD1);
`ifdef FLASH_WORD_FETCH_PREFETCH_EN
        check("pf_keep_streaming", bus.flash_do_read, 1);
`else
        check("nopf_drop_on_byte", bus.flash_do_read, 0);
`endif
        feed(8'hD2); feed(8'hD3); feed(8'hD4);
        check("idle_after_extra", bus.flash_do_read, 0);
        for (int i = 0; i < 8; i++) tick();
        req(24'h000104);
`ifdef FLASH_WORD_FETCH_PREFETCH_EN
        check("pf_hit_resp_valid", bus.resp_valid, 1);
        check("pf_hit_resp_data", bus.resp_data, 32'hD4D3D2D1);
        check("pf_hit_no_flash", bus.flash_do_read, 0);
        tick();
        check("pf_hit_pulse_end", bus.resp_valid, 0);
`else
        check("nopf_gap_resp_valid", bus.resp_valid, 0);
        check("nopf_gap_do_read", bus.flash_do_read, 0);
        check("nopf_gap_flash_addr", bus.flash_addr, 24'h000104);
        tick();
        check("nopf_stream_do_read", bus.flash_do_read, 1);
        feed(8'hE1); feed(8'hE2); feed(8'hE3); feed(8'hE4);
        check("nopf_resp_data", bus.resp_data, 32'hE4E3E2E1);
`endif

        // Reset mid-word: partial word dropped, no response
        tick();
        req(24'h000300);
        tick();
        feed(8'h5A); feed(8'h5B);
        rc0 = resp_cnt;
        rst = 1'b1;
        #1;
        check("midrst_resp_valid", bus.resp_valid, 0);
        check("midrst_do_read", bus.flash_do_read, 0);
        check("midrst_flash_addr", bus.flash_addr, 0);
        check("midrst_req_ready", bus.req_ready, 0);
        tick();
        rst = 1'b0;
        feed(8'h5C); feed(8'h5D);
        for (int i = 0; i < 4; i++) tick();
        check("midrst_no_resp", resp_cnt - rc0, 0);
        check("midrst_ready_back", bus.req_ready, 1);
        check("no_back_to_back_resp", consec, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
